// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF frame scheduler.
package spdif_pkg;

    localparam int SAMPLE_W = 24;

    localparam logic CHAN_L = 1'b0;
    localparam logic CHAN_R = 1'b1;

    typedef enum logic [1:0] {
        PAIR_UNLOCKED,
        PAIR_SYNC,
        PAIR_WAIT_R
    } pair_state_e;

    typedef enum logic [1:0] {
        PLAY_IDLE,
        PLAY_PRIME,
        PLAY_RUN
    } play_state_e;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous stereo-frame FIFO with exact registered level and flush.
module frame_fifo #(
    parameter int DW    = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            data_i,
    output logic [DW-1:0]            head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_push, do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign level_o = lvl_q;

    // A full FIFO still accepts a push when the same cycle pops.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/spdif_frame_scheduler.sv
// Pairs S/PDIF subframes into stereo frames, buffers them and
// releases one frame per next_sample request to i2s_tx.
module spdif_frame_scheduler
    import spdif_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PRIME_LVL = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lock,
    input  logic                      sub_valid,
    input  logic                      sub_chan,
    input  logic [SAMPLE_W-1:0]       sub_data,
    input  logic                      sub_par_ok,
    input  logic                      next_sample,
    input  logic                      clr_status,
    output logic [SAMPLE_W-1:0]       sample_left,
    output logic [SAMPLE_W-1:0]       sample_right,
    output logic                      playing,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      underflow,
    output logic                      overflow
);
    localparam int LW = $clog2(DEPTH) + 1;

    pair_state_e pair_q, pair_d;
    play_state_e play_q, play_d;

    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] good_l_q, good_r_q;
    logic [SAMPLE_W-1:0] out_l_q, out_l_d;
    logic [SAMPLE_W-1:0] out_r_q, out_r_d;
    logic                uf_q, uf_d;
    logic                of_q, of_d;

    logic [SAMPLE_W-1:0]   word;
    logic                  push_req, push, pop, starve;
    logic                  full, empty;
    logic [2*SAMPLE_W-1:0] head;
    logic [LW-1:0]         level;

    // Parity failures substitute the channel's last good sample.
    assign word = sub_par_ok ? sub_data
                : (sub_chan == CHAN_R) ? good_r_q : good_l_q;

    always_comb begin
        pair_d   = pair_q;
        left_d   = left_q;
        push_req = 1'b0;
        if (!lock) begin
            pair_d = PAIR_UNLOCKED;
        end else begin
            unique case (pair_q)
                PAIR_UNLOCKED: pair_d = PAIR_SYNC;
                PAIR_SYNC: begin
                    if (sub_valid && sub_chan == CHAN_L) begin
                        left_d = word;
                        pair_d = PAIR_WAIT_R;
                    end
                end
                PAIR_WAIT_R: begin
                    if (sub_valid && sub_chan == CHAN_L) begin
                        left_d = word;
                    end else if (sub_valid) begin
                        push_req = 1'b1;
                        pair_d   = PAIR_SYNC;
                    end
                end
                default: pair_d = PAIR_UNLOCKED;
            endcase
        end
    end

    always_comb begin
        play_d  = play_q;
        out_l_d = out_l_q;
        out_r_d = out_r_q;
        pop     = 1'b0;
        starve  = 1'b0;
        if (!lock) begin
            play_d  = PLAY_IDLE;
            out_l_d = '0;
            out_r_d = '0;
        end else begin
            unique case (play_q)
                PLAY_IDLE: play_d = PLAY_PRIME;
                PLAY_PRIME: begin
                    if (level >= LW'(PRIME_LVL)) play_d = PLAY_RUN;
                end
                PLAY_RUN: begin
                    if (next_sample && !empty) begin
                        pop                = 1'b1;
                        {out_l_d, out_r_d} = head;
                    end else if (next_sample) begin
                        starve  = 1'b1;
                        out_l_d = '0;
                        out_r_d = '0;
                        play_d  = PLAY_PRIME;
                    end
                end
                default: play_d = PLAY_IDLE;
            endcase
        end
    end

    assign push = push_req && (!full || pop);
    assign uf_d = starve | (uf_q & ~clr_status);
    assign of_d = (push_req & full & ~pop) | (of_q & ~clr_status);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_q   <= PAIR_UNLOCKED;
            play_q   <= PLAY_IDLE;
            left_q   <= '0;
            good_l_q <= '0;
            good_r_q <= '0;
            out_l_q  <= '0;
            out_r_q  <= '0;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            play_q  <= play_d;
            left_q  <= left_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
            uf_q    <= uf_d;
            of_q    <= of_d;
            if (sub_valid && sub_par_ok) begin
                if (sub_chan == CHAN_R) good_r_q <= sub_data;
                else                    good_l_q <= sub_data;
            end
        end
    end

    frame_fifo #(
        .DW    (2 * SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (!lock),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({left_q, word}),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign sample_left  = out_l_q;
    assign sample_right = out_r_q;
    assign playing      = (play_q == PLAY_RUN);
    assign fifo_level   = level;
    assign underflow    = uf_q;
    assign overflow     = of_q;

endmodule

// File: tb/tb_spdif_frame_scheduler.sv
// Scoreboard bench: frame-queue reference model vs spdif_frame_scheduler.
module tb_spdif_frame_scheduler;
    import spdif_pkg::*;

    localparam int DEPTH = 8;
    localparam int PRIME = 4;
    localparam int W     = SAMPLE_W;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         lock = 1'b0;
    logic         sub_valid = 1'b0;
    logic         sub_chan = 1'b0;
    logic [W-1:0] sub_data = '0;
    logic         sub_par_ok = 1'b0;
    logic         next_sample = 1'b0;
    logic         clr_status = 1'b0;
    logic [W-1:0] sample_left, sample_right;
    logic         playing, underflow, overflow;
    logic [LW-1:0] fifo_level;

    always #13 clk = ~clk;

    spdif_frame_scheduler #(.DEPTH(DEPTH), .PRIME_LVL(PRIME)) dut (
        .clk          (clk),
        .reset        (reset),
        .lock         (lock),
        .sub_valid    (sub_valid),
        .sub_chan     (sub_chan),
        .sub_data     (sub_data),
        .sub_par_ok   (sub_par_ok),
        .next_sample  (next_sample),
        .clr_status   (clr_status),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .playing      (playing),
        .fifo_level   (fifo_level),
        .underflow    (underflow),
        .overflow     (overflow)
    );

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           lvl;
        bit           pl;
        bit           uf;
        bit           of;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    // Driver-side intent for the next clock edge.
    bit           d_rst = 1, d_lock = 0, d_sv = 0, d_ch = 0;
    bit           d_ok = 0, d_ns = 0, d_clr = 0;
    logic [W-1:0] d_data = '0;

    // Reference model: buffered frames plus a few flags.
    logic [2*W-1:0] mq[$];
    bit             m_sync, m_hasl, m_act, m_play, m_uf, m_of;
    logic [W-1:0]   m_left, m_gl, m_gr, m_ol, m_or;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic void model();
        logic [W-1:0] w;
        bit           pop, ufl, set_uf, set_of;
        int           n;
        exp_t         e;
        set_uf = 0;
        set_of = 0;
        if (reset) begin
            mq.delete();
            {m_sync, m_hasl, m_act, m_play, m_uf, m_of} = '0;
            m_left = '0; m_gl = '0; m_gr = '0;
            m_ol = '0; m_or = '0;
        end else begin
            if (!lock) begin
                mq.delete();
                {m_sync, m_hasl, m_act, m_play} = '0;
                m_ol = '0; m_or = '0;
            end else begin
                n   = mq.size();
                pop = m_play && next_sample && n > 0;
                ufl = m_play && next_sample && n == 0;
                w   = sub_par_ok ? sub_data : (sub_chan ? m_gr : m_gl);
                if (pop) {m_ol, m_or} = mq.pop_front();
                if (ufl) begin
                    m_ol = '0; m_or = '0; set_uf = 1;
                end
                if (!m_sync) m_sync = 1;
                else if (sub_valid && !sub_chan) begin
                    m_left = w; m_hasl = 1;
                end else if (sub_valid && m_hasl) begin
                    if (mq.size() < DEPTH) mq.push_back({m_left, w});
                    else set_of = 1;
                    m_hasl = 0;
                end
                if (!m_act) m_act = 1;
                else if (ufl) m_play = 0;
                else if (!m_play && n >= PRIME) m_play = 1;
            end
            if (sub_valid && sub_par_ok) begin
                if (sub_chan) m_gr = sub_data;
                else          m_gl = sub_data;
            end
            m_uf = set_uf | (m_uf & !clr_status);
            m_of = set_of | (m_of & !clr_status);
        end
        e.l   = m_ol;
        e.r   = m_or;
        e.lvl = mq.size();
        e.pl  = m_play;
        e.uf  = m_uf;
        e.of  = m_of;
        expq.push_back(e);
    endfunction

    task automatic step();
        @(negedge clk);
        if (d_rst && !reset) begin
            reset = 1'b1;
            #1;
            chk("async_rst_left", 64'(sample_left), 64'd0);
            chk("async_rst_right", 64'(sample_right), 64'd0);
            chk("async_rst_level", 64'(fifo_level), 64'd0);
            chk("async_rst_playing", 64'(playing), 64'd0);
        end
        reset       = d_rst;
        lock        = d_lock;
        sub_valid   = d_sv;
        sub_chan    = d_ch;
        sub_data    = d_data;
        sub_par_ok  = d_ok;
        next_sample = d_ns;
        clr_status  = d_clr;
        model();
    endtask

    task automatic sub(bit ch, logic [W-1:0] d, bit ok = 1);
        d_sv = 1; d_ch = ch; d_data = d; d_ok = ok;
        step();
        d_sv = 0; d_ok = 0;
    endtask

    task automatic ns();
        d_ns = 1;
        step();
        d_ns = 0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic pair(logic [W-1:0] l, logic [W-1:0] r);
        sub(CHAN_L, l);
        idle(1);
        sub(CHAN_R, r);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("sample_left", 64'(sample_left), 64'(e.l));
                chk("sample_right", 64'(sample_right), 64'(e.r));
                chk("fifo_level", 64'(fifo_level), 64'(e.lvl));
                chk("playing", 64'(playing), 64'(e.pl));
                chk("underflow", 64'(underflow), 64'(e.uf));
                chk("overflow", 64'(overflow), 64'(e.of));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        idle(2);
        d_rst = 0;
        idle(1);
        d_lock = 1;
        idle(2);
        for (int n = 0; n < 6; n++) pair(W'(24'h000100 + n), W'(24'h800000 + n));
        idle(2);
        for (int n = 0; n < 6; n++) begin
            ns();
            idle(2);
        end
        ns();
        idle(2);
        ns();
        idle(1);
        d_clr = 1;
        step();
        d_clr = 0;
        for (int n = 0; n < 4; n++) pair(W'(24'h010000 + n), W'(24'h020000 + n));
        idle(3);
        for (int n = 0; n < 4; n++) pair(W'(24'h030000 + n), W'(24'h040000 + n));
        pair(24'hDEAD01, 24'hDEAD02);
        idle(2);
        for (int n = 0; n < 9; n++) begin
            ns();
            idle(1);
        end
        sub(CHAN_L, 24'h123456);
        sub(CHAN_L, 24'h654321, 0);
        sub(CHAN_R, 24'h0F0F0F);
        sub(CHAN_L, 24'hAAAAAA);
        sub(CHAN_L, 24'hBBBBBB);
        sub(CHAN_R, 24'hCCCCCC);
        sub(CHAN_R, 24'h777777, 0);
        for (int n = 0; n < 4; n++) pair(W'(24'h050000 + n), W'(24'h060000 + n));
        idle(3);
        for (int n = 0; n < 4; n++) begin
            ns();
            idle(1);
        end
        d_lock = 0;
        idle(2);
        d_lock = 1;
        idle(2);
        for (int n = 0; n < 5; n++) pair(W'(24'h070000 + n), W'(24'h080000 + n));
        idle(2);
        ns();
        sub(CHAN_L, 24'h111111);
        d_rst = 1;
        idle(2);
        d_rst = 0;
        idle(2);
        for (int i = 0; i < 2500; i++) begin
            d_rst  = ($urandom_range(0, 999) < 3);
            if ($urandom_range(0, 99) < 2) d_lock = ~d_lock;
            d_sv   = ($urandom_range(0, 99) < 45);
            d_ch   = ($urandom_range(0, 99) < 50);
            d_data = W'($urandom());
            d_ok   = ($urandom_range(0, 99) < 90);
            d_ns   = ($urandom_range(0, 99) < 25);
            d_clr  = ($urandom_range(0, 99) < 3);
            step();
        end
        {d_rst, d_sv, d_ok, d_ns, d_clr} = '0;
        idle(3);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
